// File: rtl/result_tx.sv
// result_tx: captures CPU result-bus writes into a small FIFO and sends each word LSB-first as an async serial frame.
// Define RESULT_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module result_tx #(
    parameter int n            = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [n-1:0] data_in,
    input  logic         valid,
    output logic         tx,
    output logic         busy,
    output logic         full,
    output logic         overflow
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int BW = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [15:0]   BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(n - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_next;

    logic [n-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push, pop;
    logic [15:0]   baud, baud_next;
    logic [BW-1:0] bit_idx, bit_next;
    logic [n-1:0]  shreg, sh_next;
    logic          tx_next;
`ifdef RESULT_TX_PARITY_EN
    logic          par, par_next;
`endif

    // A full FIFO rejects the capture even when the transmitter pops on the same edge.
    assign push     = valid && (count != FULL_CNT);
    assign full     = (count == FULL_CNT);
    assign busy     = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (valid && (count == FULL_CNT))
                overflow <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud;
        bit_next   = bit_idx;
        sh_next    = shreg;
        pop        = 1'b0;
`ifdef RESULT_TX_PARITY_EN
        par_next   = par;
`endif
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop        = 1'b1;
                    state_next = START;
                    baud_next  = '0;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = DATA;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    sh_next   = shreg >> 1;
                    if (bit_idx == BIT_LAST) begin
`ifdef RESULT_TX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`ifdef RESULT_TX_PARITY_EN
            PARITY: begin
                if (baud == BAUD_LAST) begin
                    baud_next  = '0;
                    state_next = STOP;
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next start bit so queued frames leave no idle gap.
                if (baud == BAUD_LAST) begin
                    baud_next = '0;
                    if (count != '0) begin
                        pop        = 1'b1;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (pop) begin
            sh_next = mem[rd_ptr];
`ifdef RESULT_TX_PARITY_EN
            par_next = ^mem[rd_ptr];
`endif
        end

        // tx is registered, so it is driven from the state being entered.
        tx_next = 1'b1;
        if (state_next == START)
            tx_next = 1'b0;
        else if (state_next == DATA)
            tx_next = sh_next[0];
`ifdef RESULT_TX_PARITY_EN
        else if (state_next == PARITY)
            tx_next = par_next;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
`ifdef RESULT_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            baud    <= baud_next;
            bit_idx <= bit_next;
            shreg   <= sh_next;
            tx      <= tx_next;
`ifdef RESULT_TX_PARITY_EN
            par     <= par_next;
`endif
        end
    end
endmodule

// File: tb/tb_result_tx.sv
// Bench for result_tx: a line receiver decodes tx frames and checks them against a queue of words the FIFO should accept.
module tb_result_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef RESULT_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int FRAME = FB * CPB;

    logic       clk, reset, valid;
    logic [7:0] data_in;
    logic       tx, busy, full, overflow;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [7:0] exp_q[$];
    int start_q[$];

    result_tx #(.n(8), .CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid(valid),
        .tx(tx), .busy(busy), .full(full), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver: samples every cycle of a frame, requires each bit constant, decodes the byte.
    logic [FB-1:0] rx_bits;
    logic          rx_abort, rx_stable;
    int            rx_start;
    always begin
        @(negedge clk);
        if (!reset && tx === 1'b0) begin
            rx_start  = cyc;
            rx_abort  = 1'b0;
            rx_stable = 1'b1;
            rx_bits   = '0;
            for (int i = 1; i < FRAME; i++) begin
                @(negedge clk);
                if (reset) rx_abort = 1'b1;
                if (i % CPB == 0) rx_bits[i / CPB] = tx;
                else if (tx !== rx_bits[i / CPB]) rx_stable = 1'b0;
            end
            if (!rx_abort) begin
                start_q.push_back(rx_start);
                check("rx_bit_stable", 32'(rx_stable), 32'd1);
                check("rx_stop_bit", 32'(rx_bits[FB-1]), 32'd1);
`ifdef RESULT_TX_PARITY_EN
                check("rx_parity", 32'(rx_bits[9]), 32'(^rx_bits[8:1]));
`endif
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $error("FAIL rx_unexpected_frame: observed %0h expected no frame", rx_bits[8:1]);
                end else begin
                    check("rx_data", 32'(rx_bits[8:1]), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic push(input logic [7:0] d);
        valid   = 1'b1;
        data_in = d;
        @(negedge clk);
        valid   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_idle(output int fall_cyc);
        int t;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $error("FAIL wait_idle_timeout: observed busy=%b required 0", busy);
        end
        fall_cyc = cyc;
    endtask

    initial begin
        int k, t, len, acc;
        logic [7:0] d;
        reset = 1'b1; valid = 1'b0; data_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single word 0xA5
        exp_q.push_back(8'hA5);
        start_q.delete();
        push(8'hA5);
        k = cyc;
        check("t1_tx_idle_after_capture", 32'(tx), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_tx_start", 32'(tx), 32'd0);
        wait_idle(t);
        check("t1_busy_fall_cycle", 32'(t), 32'(k + 1 + FRAME));
        check("t1_nframes", 32'(start_q.size()), 32'd1);

        // Back-to-back 0x00, 0xFF
        start_q.delete();
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        valid = 1'b1; data_in = 8'h00;
        @(negedge clk);
        k = cyc;
        data_in = 8'hFF;
        @(negedge clk);
        valid = 1'b0;
        wait_idle(t);
        check("t2_span", 32'(t - (k + 1)), 32'(2 * FRAME));
        check("t2_nframes", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2) check("t2_gap", 32'(start_q[1] - start_q[0]), 32'(FRAME));

        // Overflow: six consecutive captures 0x01..0x06
        valid = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            data_in = 8'(i);
            if (i <= 5) exp_q.push_back(8'(i));
            @(negedge clk);
            if (i == 2) check("t3_first_pop_tx", 32'(tx), 32'd0);
            if (i == 4) check("t3_not_full", 32'(full), 32'd0);
            if (i == 5) begin
                check("t3_full", 32'(full), 32'd1);
                check("t3_no_overflow_yet", 32'(overflow), 32'd0);
            end
        end
        valid = 1'b0;
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_full_after_drop", 32'(full), 32'd1);
        wait_idle(t);
        check("t3_overflow_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("t3_overflow_cleared", 32'(overflow), 32'd0);

        // Push at full on the STOP->START pop edge
        k = 0;
        for (int i = 0; i < 5; i++) begin
            d = 8'($urandom_range(0, 255));
            exp_q.push_back(d);
            valid = 1'b1; data_in = d;
            @(negedge clk);
            if (i == 0) k = cyc;
        end
        valid = 1'b0;
        while (cyc < k + FRAME) @(negedge clk);
        check("t4_full_before", 32'(full), 32'd1);
        check("t4_overflow_before", 32'(overflow), 32'd0);
        push(8'($urandom_range(0, 255)));
        check("t4_overflow", 32'(overflow), 32'd1);
        check("t4_count_dropped", 32'(full), 32'd0);
        wait_idle(t);
        do_reset();

        // Reset during data bit 3 of 0x3C
        push(8'h3C);
        k = cyc;
        while (cyc < k + 18) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t5_tx", 32'(tx), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_full", 32'(full), 32'd0);
        check("t5_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        while (cyc < k + 30) @(negedge clk);
        check("t5_frame_aborted", 32'(tx), 32'd1);
        repeat (FRAME) @(negedge clk);
        exp_q.push_back(8'h81);
        push(8'h81);
        wait_idle(t);

        // Ten words 0x10..0x19 spaced at least one frame apart
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(8'(8'h10 + i));
            push(8'(8'h10 + i));
            repeat (FRAME + $urandom_range(0, 8)) @(negedge clk);
        end
        wait_idle(t);
        check("t6_no_overflow", 32'(overflow), 32'd0);

        // Random bursts from idle: DEPTH words plus the one in flight survive
        for (int b = 0; b < 4; b++) begin
            len = $urandom_range(1, 9);
            acc = (len < DEPTH + 1) ? len : DEPTH + 1;
            valid = 1'b1;
            for (int i = 0; i < len; i++) begin
                d = 8'($urandom_range(0, 255));
                if (i < acc) exp_q.push_back(d);
                data_in = d;
                @(negedge clk);
            end
            valid = 1'b0;
            wait_idle(t);
            check("t7_burst_overflow", 32'(overflow), 32'(len > DEPTH + 1));
            do_reset();
        end

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/result_tx.md
# result_tx

Serial transmitter for the picoMIPS result bus. It captures each 8-bit value the CPU writes to its register file/LED output and queues it in a small FIFO. It then shifts the value out LSB-first as an asynchronous 8N1 frame on a single `tx` line, so a host terminal can log results without reading the LEDs. It sits beside the CPU top level: `data_in` taps the write-data bus and `valid` taps the register write-enable.

## Interface
Parameters:
- `n`, 8: data width of captured words; frame carries n data bits.
- `CLKS_PER_BIT`, 434: clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
- `DEPTH`, 4: FIFO depth in words; power of two, 2..16.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  n  word to capture (CPU write-data bus).
- `valid`  in  1  capture strobe; `data_in` is pushed on every rising edge where `valid`=1.
- `tx`  out  1  serial line, idle high, registered.
- `busy`  out  1  high while a frame is on the line or the FIFO is non-empty.
- `full`  out  1  FIFO holds DEPTH words.
- `overflow`  out  1  sticky flag: a capture was dropped because the FIFO was full.

## Operation
- Reset (`reset`=1 at an edge):
  - `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - FIFO emptied, state = IDLE, bit counter and baud counter = 0.
  - Reset mid-frame aborts the frame immediately; no stop bit is completed.
- FIFO:
  - Circular buffer, read/write pointers wrap modulo DEPTH, occupancy count 0..DEPTH.
  - Push when `valid`=1 and count<DEPTH.
  - When count==DEPTH, the push is rejected and `overflow` sets, even if a pop occurs on the same edge.
  - Simultaneous push and pop with 0<count<DEPTH leaves count unchanged.
  - There is no bypass: a word pushed into an empty FIFO is visible to the transmitter on the next cycle.
- State machine: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: n bits, LSB first, each held CLKS_PER_BIT cycles. Shift right at the end of each bit.
  - PARITY: present only with the macro (see Configuration).
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. On its last cycle, if the FIFO is non-empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1; the bit boundary is at count==CLKS_PER_BIT-1.
- `busy` = (state≠IDLE) or (count≠0).
- `overflow` clears only on reset.

## Timing
- Capture latency: `valid` sampled at edge k → word in FIFO after edge k.
- Transmit latency from empty/IDLE: IDLE pops at edge k+1, and `tx` falls after edge k+1. That is 2 edges from the `valid` sample to the start bit.
- Frame length: (n+2)·CLKS_PER_BIT cycles; (n+3)·CLKS_PER_BIT with parity.
- Back-to-back frames are contiguous: start bit follows stop bit with zero extra cycles.
- `full` and `overflow` update on the same edge as the push/drop that causes them.
- Sustained throughput: one word per frame time. Bursts longer than DEPTH plus one in-flight word, arriving faster than the frame rate, drop the excess.

## Configuration
- `RESULT_TX_PARITY_EN` defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the n data bits) for CLKS_PER_BIT cycles.
  - Frame is n+3 bits.
- Not defined: no PARITY state; frame is n+2 bits (8N1 for n=8).

## Test plan
All scenarios use n=8, CLKS_PER_BIT=4, DEPTH=4.
- Single word: reset, then one-cycle `valid` with 0xA5.
  - `tx` falls 2 edges later.
  - Line shows 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total).
  - `busy` falls after the last stop cycle.
  - With the parity macro, the parity bit is 0 before stop (44 cycles total).
- Back-to-back: push 0x00 then 0xFF on consecutive cycles.
  - Second start bit begins on the cycle immediately after the first stop bit's 4th cycle.
  - Total line-low-to-idle span is 80 cycles.
- Overflow: hold `valid` for 6 cycles with 0x01..0x06.
  - First word pops to the transmitter at the second edge.
  - `full` asserts after the 5th push; the 6th push is dropped and `overflow`=1.
  - Line transmits 0x01..0x05 only.
- Simultaneous push/pop at full: fill the FIFO, then assert `valid` on the STOP→START pop edge.
  - Word is dropped, `overflow` sets, count goes DEPTH→DEPTH-1.
- Reset mid-frame: assert `reset` during DATA bit 3 of 0x3C.
  - Next edge: `tx`=1, `busy`=0, `full`=0, `overflow`=0.
  - A new push of 0x81 transmits a clean full frame.
- Wrap-around: push and transmit 10 words 0x10..0x19, spaced one frame apart.
  - All received in order with correct values across pointer wrap.
  - `overflow` stays 0.
